// File: rtl/sc_fe_pkg.sv
// Shared definitions for the switched-capacitor front-end phase sequencer.
package sc_fe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RST  = 3'd1,
    ST_GAP1 = 3'd2,
    ST_INT  = 3'd3,
    ST_GAP2 = 3'd4,
    ST_SAMP = 3'd5,
    ST_NEXT = 3'd6
  } state_e;

  // Analog switch bundle per channel; bit i drives switch s(i+1).
  localparam int unsigned NUM_SW = 6;
  localparam logic [NUM_SW-1:0] SW_MAP_A = 6'b100100;  // s3, s6 (reset)
  localparam logic [NUM_SW-1:0] SW_MAP_B = 6'b011010;  // s2, s4, s5 (integrate)

endpackage

// File: rtl/sc_phase_sequencer_if.sv
// ADC conversion handshake between the phase sequencer (master) and the converter (slave).
interface sc_phase_sequencer_if #(
  parameter int unsigned NUM_CH = 4
);
  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [IDX_W-1:0] ch_idx;
  logic             sample_req;
  logic             sample_ack;

  modport master (output ch_idx, output sample_req, input sample_ack);
  modport slave  (input ch_idx, input sample_req, output sample_ack);
endinterface

// File: rtl/sc_next_ch.sv
// Finds the next enabled channel strictly above cur, wrapping to the lowest enabled one.
module sc_next_ch #(
  parameter  int unsigned NUM_CH = 4,
  localparam int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [IDX_W-1:0]  cur,
  output logic [IDX_W-1:0]  nxt,
  output logic              wrap,
  output logic              any
);

  logic [IDX_W-1:0] lo_idx;
  logic [IDX_W-1:0] hi_idx;
  logic             hi_found;

  // Descending scan: the last hit is the lowest index that qualifies.
  always_comb begin
    lo_idx   = '0;
    hi_idx   = '0;
    hi_found = 1'b0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lo_idx = IDX_W'(i);
        if (i > int'(cur)) begin
          hi_idx   = IDX_W'(i);
          hi_found = 1'b1;
        end
      end
    end
  end

  assign nxt  = hi_found ? hi_idx : lo_idx;
  assign wrap = !hi_found;
  assign any  = |mask;

endmodule

// File: rtl/sc_phase_sequencer.sv
// Round-robin reset/integrate/sample sequencer for the switched-capacitor ECG channels,
// with break-before-make dead time and an ADC req/ack handshake guarded by a timeout.
module sc_phase_sequencer
  import sc_fe_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned ACK_TO = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [CNT_W-1:0]  cfg_t_a,
  input  logic [CNT_W-1:0]  cfg_t_b,
  input  logic [CNT_W-1:0]  cfg_t_dead,
  input  logic [NUM_CH-1:0] cfg_ch_en,
  output logic [NUM_CH-1:0] sw_a,
  output logic [NUM_CH-1:0] sw_b,
  output logic [2:0]        state,
  output logic              frame_done,
  output logic              err_timeout,
  output logic              err_cfg,
  sc_phase_sequencer_if.master adc
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned TO_W  = $clog2(ACK_TO + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [IDX_W-1:0]  ch_q, ch_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]  ta_q, ta_d, tb_q, tb_d, td_q, td_d;
  logic [NUM_CH-1:0] sw_a_q, sw_a_d, sw_b_q, sw_b_d;
  logic              req_q, req_d, done_q, done_d;
  logic              err_to_q, err_to_d, err_cfg_q, err_cfg_d;
  logic              latch;

  logic [IDX_W-1:0]  nxt_ch, first_ch;
  logic              wrap, any_new;
  logic              unused_any_cur, unused_wrap_first;

  // Successor of the channel in flight within the frame's latched mask.
  sc_next_ch #(.NUM_CH(NUM_CH)) u_next_cur (
    .mask (mask_q),
    .cur  (ch_q),
    .nxt  (nxt_ch),
    .wrap (wrap),
    .any  (unused_any_cur)
  );

  // Searching above the top index yields the lowest enabled channel of the live mask.
  sc_next_ch #(.NUM_CH(NUM_CH)) u_first_new (
    .mask (cfg_ch_en),
    .cur  (IDX_W'(NUM_CH - 1)),
    .nxt  (first_ch),
    .wrap (unused_wrap_first),
    .any  (any_new)
  );

  // Load value for a duration of max(t,1) cycles.
  function automatic logic [CNT_W-1:0] dm1(input logic [CNT_W-1:0] t);
    return (t == '0) ? '0 : t - CNT_W'(1);
  endfunction

  function automatic logic [NUM_CH-1:0] onehot(input logic [IDX_W-1:0] i);
    return NUM_CH'(1) << i;
  endfunction

  // Next-state and next-output logic; switch/req/done outputs default to off.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    ch_d      = ch_q;
    mask_d    = mask_q;
    ta_d      = ta_q;
    tb_d      = tb_q;
    td_d      = td_q;
    sw_a_d    = '0;
    sw_b_d    = '0;
    req_d     = 1'b0;
    done_d    = 1'b0;
    err_to_d  = err_to_q;
    err_cfg_d = err_cfg_q;
    latch     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run) begin
          if (any_new) begin
            latch    = 1'b1;
            err_to_d = 1'b0;
          end else begin
            err_cfg_d = 1'b1;
          end
        end
      end
      ST_RST: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP1;
          cnt_d   = dm1(td_q);
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          sw_a_d = onehot(ch_q);
        end
      end
      ST_GAP1: begin
        if (cnt_q == '0) begin
          state_d = ST_INT;
          cnt_d   = dm1(tb_q);
          sw_b_d  = onehot(ch_q);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_INT: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP2;
          cnt_d   = dm1(td_q);
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          sw_b_d = onehot(ch_q);
        end
      end
      ST_GAP2: begin
        if (cnt_q == '0) begin
          state_d = ST_SAMP;
          to_d    = '0;
          req_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SAMP: begin
        if (adc.sample_ack) begin
          state_d = ST_NEXT;
          done_d  = wrap;
        end else if (to_q == TO_W'(ACK_TO - 1)) begin
          state_d  = ST_NEXT;
          done_d   = wrap;
          err_to_d = 1'b1;
        end else begin
          to_d  = to_q + TO_W'(1);
          req_d = 1'b1;
        end
      end
      ST_NEXT: begin
        if (!wrap) begin
          state_d = ST_RST;
          ch_d    = nxt_ch;
          cnt_d   = dm1(ta_q);
          sw_a_d  = onehot(nxt_ch);
        end else if (run && any_new) begin
          latch = 1'b1;
        end else begin
          state_d = ST_IDLE;
          ch_d    = nxt_ch;
          if (run) err_cfg_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame start: configuration is captured only here.
    if (latch) begin
      mask_d  = cfg_ch_en;
      ta_d    = cfg_t_a;
      tb_d    = cfg_t_b;
      td_d    = cfg_t_dead;
      ch_d    = first_ch;
      state_d = ST_RST;
      cnt_d   = dm1(cfg_t_a);
      sw_a_d  = onehot(first_ch);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      to_q      <= '0;
      ch_q      <= '0;
      mask_q    <= '0;
      ta_q      <= '0;
      tb_q      <= '0;
      td_q      <= '0;
      sw_a_q    <= '0;
      sw_b_q    <= '0;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      err_to_q  <= 1'b0;
      err_cfg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      ch_q      <= ch_d;
      mask_q    <= mask_d;
      ta_q      <= ta_d;
      tb_q      <= tb_d;
      td_q      <= td_d;
      sw_a_q    <= sw_a_d;
      sw_b_q    <= sw_b_d;
      req_q     <= req_d;
      done_q    <= done_d;
      err_to_q  <= err_to_d;
      err_cfg_q <= err_cfg_d;
    end
  end

  assign state          = state_q;
  assign sw_a           = sw_a_q;
  assign sw_b           = sw_b_q;
  assign frame_done     = done_q;
  assign err_timeout    = err_to_q;
  assign err_cfg        = err_cfg_q;
  assign adc.ch_idx     = ch_q;
  assign adc.sample_req = req_q;

endmodule
